// File: rtl/pulse_delay_pkg.sv
// Shared width helpers for the pulse delay line.
package pulse_delay_pkg;

   // Timestamp width: wide enough that DELAY < 2^width, so due-compares never alias.
   function automatic int ts_width(input int delay);
      return $clog2(delay) + 1;
   endfunction

   // Occupancy counter width: holds 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pulse_delay_ts_fifo.sv
// First-word-fall-through FIFO of due timestamps, with synchronous flush.
module ts_fifo
   import pulse_delay_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        n_reset,
   input  logic                        push,
   input  logic                        pop,
   input  logic                        flush,
   input  logic [WIDTH-1:0]            din,
   output logic [WIDTH-1:0]            head,
   output logic                        full,
   output logic                        empty,
   output logic [cnt_width(DEPTH)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage write; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign full  = (r_count == CNT_W'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule

// File: rtl/pulse_delay.sv
// Re-emits each input pulse exactly DELAY cycles later; up to DEPTH pulses in flight.
module pulse_delay
   import pulse_delay_pkg::*;
#(
   parameter int DELAY = 1000,
   parameter int DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        n_reset,
   input  logic                        in,
   input  logic                        flush,
   input  logic                        clr_ovf,
   output logic                        out,
   output logic [cnt_width(DEPTH)-1:0] pending,
   output logic                        busy,
   output logic                        overflow
);

   localparam int TS_W  = ts_width(DELAY);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [TS_W-1:0]  r_now;
   logic             r_out;
   logic             r_overflow;
   logic [TS_W-1:0]  w_now_next;
   logic [TS_W-1:0]  w_due;
   logic [TS_W-1:0]  w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [CNT_W-1:0] w_count;

   // Free-running timestamp; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) r_now <= '0;
      else          r_now <= r_now + TS_W'(1);
   end

   assign w_now_next = r_now + TS_W'(1);
   assign w_due      = r_now + TS_W'(DELAY);

   // The head is matched one timestamp early because out is registered,
   // which makes the edge-to-edge latency exactly DELAY.
   assign w_pop  = !w_empty && !flush && (w_head == w_now_next);
   assign w_push = in && !flush && (!w_full || w_pop);
   assign w_drop = in && !flush && w_full && !w_pop;

   ts_fifo #(
      .WIDTH (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .push    (w_push),
      .pop     (w_pop),
      .flush   (flush),
      .din     (w_due),
      .head    (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   // Registered one-cycle output pulse.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) r_out <= 1'b0;
      else          r_out <= w_pop;
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)     r_overflow <= 1'b0;
      else if (w_drop)  r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
   end

   assign out      = r_out;
   assign pending  = w_count;
   assign busy     = (w_count != '0);
   assign overflow = r_overflow;

endmodule

// File: tb/tb_pulse_delay.sv
// Scoreboard bench for pulse_delay with DELAY=10, DEPTH=4.
module tb_pulse_delay;

   localparam int DELAY = 10;
   localparam int DEPTH = 4;

   logic       clk;
   logic       n_reset;
   logic       in;
   logic       flush;
   logic       clr_ovf;
   logic       out;
   logic [2:0] pending;
   logic       busy;
   logic       overflow;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_q[$];

   pulse_delay #(
      .DELAY (DELAY),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .in       (in),
      .flush    (flush),
      .clr_ovf  (clr_ovf),
      .out      (out),
      .pending  (pending),
      .busy     (busy),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every out pulse must match the oldest expected cycle.
   always @(negedge clk) begin
      if (n_reset) begin
         while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_out: got none expected pulse at cycle %0d", exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (out) begin
            total++;
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin
               void'(exp_q.pop_front());
            end else begin
               bad++;
               $display("FAIL unexpected_out: got pulse at cycle %0d expected none", cyc);
            end
         end
      end
   end

   // One cycle of stimulus; acc means the pulse is expected to be accepted.
   task automatic step(input logic i, input logic f, input logic c, input bit acc);
      in      = i;
      flush   = f;
      clr_ovf = c;
      if (acc) exp_q.push_back(cyc + DELAY);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      n_reset = 1'b0;
      in      = 1'b0;
      flush   = 1'b0;
      clr_ovf = 1'b0;
      #3;
      chk("rst_out", out, 0);
      chk("rst_pending", pending, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      @(negedge clk);
      n_reset = 1'b1;
      idle(3);

      // single pulse at rel 5 -> out at rel 15, pending 1 during 6..14
      idle(5);
      step(1, 0, 0, 1);
      chk("t1_pend_6", pending, 1);
      chk("t1_busy_6", busy, 1);
      idle(8);
      chk("t1_pend_14", pending, 1);
      idle(1);
      chk("t1_pend_15", pending, 0);
      chk("t1_busy_15", busy, 0);
      idle(5);

      // burst at rel 3,4,5 -> outs at 13,14,15
      idle(3);
      repeat (3) step(1, 0, 0, 1);
      chk("t2_pend_peak", pending, 3);
      idle(15);

      // overflow: rel 0..4, fifth pulse dropped; clear at rel 20
      repeat (4) step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      chk("t3_ovf_5", overflow, 1);
      chk("t3_pend_5", pending, 4);
      idle(15);
      chk("t3_ovf_20", overflow, 1);
      step(0, 0, 1, 0);
      chk("t3_ovf_21", overflow, 0);

      // drop and clear in the same cycle: drop wins
      repeat (4) step(1, 0, 0, 1);
      step(1, 0, 1, 0);
      chk("t3b_ovf_drop_wins", overflow, 1);
      step(0, 0, 1, 0);
      chk("t3b_ovf_cleared", overflow, 0);
      idle(10);

      // full with pop: rel 0..3 fill, rel 9 push coincides with first pop
      repeat (4) step(1, 0, 0, 1);
      idle(5);
      step(1, 0, 0, 1);
      chk("t4_pend_10", pending, 4);
      chk("t4_ovf_10", overflow, 0);
      idle(12);

      // spaced pulses, timestamp keeps wrapping through these tests
      step(1, 0, 0, 1);
      idle(6);
      step(1, 0, 0, 1);
      idle(2);
      step(1, 0, 0, 1);
      idle(14);

      // flush discards in-flight pulses and a same-cycle input
      step(1, 0, 0, 1);
      idle(1);
      step(1, 0, 0, 1);
      idle(2);
      exp_q.delete();
      step(1, 1, 0, 0);
      chk("t6_pend_flush", pending, 0);
      chk("t6_ovf_flush", overflow, 0);
      idle(14);

      // flush on the pop edge suppresses the out pulse
      step(1, 0, 0, 1);
      idle(8);
      exp_q.delete();
      step(0, 1, 0, 0);
      chk("t6b_pend", pending, 0);
      idle(5);

      // asynchronous reset while out is high
      repeat (4) step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      idle(5);
      chk("t7_out_before", out, 1);
      #2;
      n_reset = 1'b0;
      #1;
      chk("t7_rst_out", out, 0);
      chk("t7_rst_pending", pending, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_ovf", overflow, 0);
      exp_q.delete();
      @(negedge clk);
      n_reset = 1'b1;
      idle(20);

      // still working after reset
      step(1, 0, 0, 1);
      idle(12);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
